uart_mem_loader: RTL and testbench

//  Writer side of the program/data RAM: receives a load image over a UART

---
 rtl/uart_mem_loader.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: receives a load image over an 8N1 UART line and writes 16-bit
// words into a RAM write port. While a frame is loading, busy is held high so the
// processor can be kept in reset.
//
// Frame format: HDR_BYTE, count_hi, count_lo, then count words as (hi, lo) byte pairs.
//
// Ports:
//   clock        in   system clock, posedge
//   reset        in   synchronous, active-high
//   rx           in   UART line, idle high, asynchronous to clock
//   m_data       out  word to write (holds last value)
//   m_addr       out  write address, valid while m_wren is high
//   m_wren       out  one-cycle write strobe per word
//   busy         out  load in progress
//   done         out  one-cycle pulse at the end of a frame
//   err          out  sticky framing error, cleared by reset or the next header
//   words_loaded out  words written in the current/last frame, saturating
module uart_mem_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 16,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_wren,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] WL_MAX = {1'b1, {ADDR_W{1'b0}}};

  // Bit-level receiver states
  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_START = 3'd1;
  localparam logic [2:0] R_DATA  = 3'd2;
  localparam logic [2:0] R_STOP  = 3'd3;
  localparam logic [2:0] R_BREAK = 3'd4;  // bad stop bit: wait for the line to go idle

  // Frame-level states
  localparam logic [2:0] F_HDR    = 3'd0;
  localparam logic [2:0] F_CNT_HI = 3'd1;
  localparam logic [2:0] F_CNT_LO = 3'd2;
  localparam logic [2:0] F_DAT_HI = 3'd3;
  localparam logic [2:0] F_DAT_LO = 3'd4;
  localparam logic [2:0] F_DAT_WR = 3'd5;  // strobe cycle of the low-byte step

  logic              rx_meta_q, rx_sync_q;
  logic [2:0]        rx_state_q, rx_state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_valid_q, byte_valid_d;
  logic              frame_err;

  logic [2:0]        fr_state_q, fr_state_d;
  logic [15:0]       remain_q, remain_d;
  logic [7:0]        hi_q, hi_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_wren_q, m_wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   wl_q, wl_d;

  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err    = 1'b0;

    case (rx_state_q)
      R_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = R_START;
          cnt_d      = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? R_IDLE : R_DATA;  // high at mid-start is a glitch
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            rx_state_d   = R_IDLE;
          end else begin
            frame_err  = 1'b1;
            rx_state_d = R_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_BREAK: begin
        if (rx_sync_q) rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    fr_state_d = fr_state_q;
    remain_d   = remain_q;
    hi_d       = hi_q;
    m_data_d   = m_data_q;
    m_addr_d   = m_addr_q;
    m_wren_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    wl_d       = wl_q;

    if (frame_err) begin
      err_d      = 1'b1;
      busy_d     = 1'b0;
      fr_state_d = F_HDR;
    end else begin
      case (fr_state_q)
        F_HDR: begin
          if (byte_valid_q && shift_q == HDR_BYTE) begin
            fr_state_d = F_CNT_HI;
            busy_d     = 1'b1;
            err_d      = 1'b0;
            wl_d       = '0;
            m_addr_d   = '0;
          end
        end
        F_CNT_HI: begin
          if (byte_valid_q) begin
            remain_d[15:8] = shift_q;
            fr_state_d     = F_CNT_LO;
          end
        end
        F_CNT_LO: begin
          if (byte_valid_q) begin
            remain_d[7:0] = shift_q;
            if (remain_q[15:8] == 8'd0 && shift_q == 8'd0) begin
              done_d     = 1'b1;
              busy_d     = 1'b0;
              fr_state_d = F_HDR;
            end else begin
              fr_state_d = F_DAT_HI;
            end
          end
        end
        F_DAT_HI: begin
          if (byte_valid_q) begin
            hi_d       = shift_q;
            fr_state_d = F_DAT_LO;
          end
        end
        F_DAT_LO: begin
          if (byte_valid_q) begin
            m_data_d   = DATA_W'({hi_q, shift_q});
            m_wren_d   = 1'b1;
            fr_state_d = F_DAT_WR;
          end
        end
        F_DAT_WR: begin
          // Strobe is high this cycle with the current address; advance afterwards.
          m_addr_d = m_addr_q + 1'b1;
          if (wl_q != WL_MAX) wl_d = wl_q + 1'b1;
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            fr_state_d = F_HDR;
          end else begin
            fr_state_d = F_DAT_HI;
          end
        end
        default: fr_state_d = F_HDR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= R_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      fr_state_q   <= F_HDR;
      remain_q     <= '0;
      hi_q         <= '0;
      m_data_q     <= '0;
      m_addr_q     <= '0;
      m_wren_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wl_q         <= '0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      fr_state_q   <= fr_state_d;
      remain_q     <= remain_d;
      hi_q         <= hi_d;
      m_data_q     <= m_data_d;
      m_addr_q     <= m_addr_d;
      m_wren_q     <= m_wren_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      wl_q         <= wl_d;
    end
  end

  assign m_data       = m_data_q;
  assign m_addr       = m_addr_q;
  assign m_wren       = m_wren_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: drives UART frames with random payloads and compares the
// observed RAM writes, counters and status outputs against a frame-level model.
module tb_uart_mem_loader;

  localparam int unsigned CPB   = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx    = 1'b1;
  logic [15:0]   m_data;
  logic [AW-1:0] m_addr;
  logic          m_wren;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  uart_mem_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW),
    .DATA_W      (16),
    .HDR_BYTE    (8'hA5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .m_data      (m_data),
    .m_addr      (m_addr),
    .m_wren      (m_wren),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor: record every write and count done cycles / back-to-back strobes.
  int            done_cnt  = 0;
  int            dbl_wren  = 0;
  logic          prev_wren = 1'b0;
  logic [AW+15:0] wr_q[$];
  logic [AW+15:0] exp_wr[$];
  logic [15:0]   tx_words[$];

  always @(negedge clock) begin
    if (m_wren) begin
      wr_q.push_back({m_addr, m_data});
      if (prev_wren) dbl_wren++;
    end
    prev_wren = m_wren;
    if (done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
  endtask

  task automatic check_writes();
    check_eq("n_writes", 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      check_eq($sformatf("write[%0d]", i), 32'(wr_q[i]), 32'(exp_wr[i]));
  endtask

  // Sends a full frame of n words (taking leading words from tx_words, the rest random)
  // preceded by `junk` non-header bytes, then checks the result against the model.
  task automatic run_frame(input int n, input int junk);
    int          d0;
    int          exp_wl;
    logic [15:0] w;
    logic [7:0]  b;
    wr_q.delete();
    exp_wr.delete();
    d0 = done_cnt;
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b, 1'b1);
      idle($urandom_range(0, 6));
    end
    send_byte(8'hA5, 1'b1);
    idle(4);
    check_eq("busy_after_hdr", 32'(busy), 32'd1);
    check_eq("err_after_hdr", 32'(err), 32'd0);
    check_eq("wl_after_hdr", 32'(words_loaded), 32'd0);
    send_byte(n[15:8], 1'b1);
    idle($urandom_range(0, 6));
    send_byte(n[7:0], 1'b1);
    idle($urandom_range(0, 6));
    for (int i = 0; i < n; i++) begin
      if (i < tx_words.size()) begin
        w = tx_words[i];
      end else begin
        w = 16'($urandom);
        if (i == 1) w[15:8] = 8'hA5;  // header value inside a frame is plain data
      end
      exp_wr.push_back({AW'(i % DEPTH), w});
      send_byte(w[15:8], 1'b1);
      idle($urandom_range(0, 6));
      send_byte(w[7:0], 1'b1);
      idle($urandom_range(0, 6));
    end
    idle(20);
    exp_wl = (n < int'(DEPTH)) ? n : int'(DEPTH);
    check_eq("done_pulses", 32'(done_cnt - d0), 32'd1);
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("err_end", 32'(err), 32'd0);
    check_eq("words_loaded", 32'(words_loaded), 32'(exp_wl));
    check_eq("m_addr_end", 32'(m_addr), 32'(n % DEPTH));
    if (n > 0) check_eq("m_data_hold", 32'(m_data), 32'(exp_wr[exp_wr.size()-1][15:0]));
    check_eq("dbl_wren", 32'(dbl_wren), 32'd0);
    check_writes();
    tx_words.delete();
  endtask

  initial begin
    int d0;

    // Reset and idle line
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle(100);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    check_eq("rst_m_addr", 32'(m_addr), 32'd0);
    check_eq("rst_writes", 32'(wr_q.size()), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done_cnt), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_wl", 32'(words_loaded), 32'd0);

    // Leading junk byte, then a two-word frame
    send_byte(8'h00, 1'b1);
    idle(10);
    check_eq("junk_busy", 32'(busy), 32'd0);
    tx_words.push_back(16'h1234);
    tx_words.push_back(16'hABCD);
    run_frame(2, 0);

    // Empty frame
    run_frame(0, 0);

    // Framing error on the low byte of the first word
    wr_q.delete();
    exp_wr.delete();
    d0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    idle(30);
    check_eq("ferr_err", 32'(err), 32'd1);
    check_eq("ferr_busy", 32'(busy), 32'd0);
    check_eq("ferr_done", 32'(done_cnt - d0), 32'd0);
    check_writes();
    tx_words.push_back(16'hBEEF);
    run_frame(1, 0);

    // Short low glitch on an idle line
    wr_q.delete();
    exp_wr.delete();
    d0 = done_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clock);
    idle(150);
    check_eq("glitch_busy", 32'(busy), 32'd0);
    check_eq("glitch_done", 32'(done_cnt - d0), 32'd0);
    check_eq("glitch_err", 32'(err), 32'd0);
    check_eq("glitch_addr", 32'(m_addr), 32'd1);
    check_writes();

    // Reset in the middle of the low byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    wr_q.delete();
    exp_wr.delete();
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clock);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle(150);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_addr", 32'(m_addr), 32'd0);
    check_eq("mrst_wl", 32'(words_loaded), 32'd0);
    check_writes();
    tx_words.push_back(16'h5566);
    run_frame(1, 0);

    // Random frames
    for (int k = 0; k < 3; k++) run_frame(int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));

    // Word count past the address space: addresses wrap, words_loaded saturates
    run_frame(int'(DEPTH) + 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
